// File: rtl/frame_stack.sv
// frame_stack: operand stack with hardware call frames.
// PUSH/POP/REPLACE work inside the current frame; ENTER opens a frame over the
// top N entries, and LEAVE copies the top R results down to the frame base and
// restores the caller's frame. The frame base is the underflow limit.
// Encodings: op 0 NONE, 1 PUSH, 2 POP, 3 REPLACE;
// status 0 NONE, 1 EMPTY, 2 OVERFLOW, 3 UNDERFLOW.
module frame_stack #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int FRAMES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        op_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [1:0]        frame_op_i,
  input  logic [DEPTH:0]    frame_args_i,
  input  logic [DEPTH:0]    frame_results_i,
  output logic [WIDTH-1:0]  tos_o,
  output logic [1:0]        status_o,
  output logic              frame_err_o,
  output logic              busy_o,
  output logic [FRAMES:0]   frame_depth_o
);

  localparam logic [1:0] OP_PUSH    = 2'd1;
  localparam logic [1:0] OP_POP     = 2'd2;
  localparam logic [1:0] OP_REPLACE = 2'd3;

  localparam logic [1:0] ST_NONE      = 2'd0;
  localparam logic [1:0] ST_EMPTY     = 2'd1;
  localparam logic [1:0] ST_OVERFLOW  = 2'd2;
  localparam logic [1:0] ST_UNDERFLOW = 2'd3;

  localparam logic [1:0] FOP_ENTER = 2'd1;
  localparam logic [1:0] FOP_LEAVE = 2'd2;

  localparam int ENTRIES = 2 ** DEPTH;
  localparam int NFRAMES = 2 ** FRAMES;
  localparam logic [DEPTH:0]  CAP   = (DEPTH + 1)'(ENTRIES);
  localparam logic [FRAMES:0] FCAP  = (FRAMES + 1)'(NFRAMES);
  localparam logic [DEPTH:0]  ONE_D = (DEPTH + 1)'(1);
  localparam logic [DEPTH:0]  TWO_D = (DEPTH + 1)'(2);
  localparam logic [FRAMES:0] ONE_F = (FRAMES + 1)'(1);

  typedef enum logic {S_IDLE, S_COPY} state_e;

  state_e            state_q, state_d;
  logic [DEPTH:0]    idx_q, idx_d;
  logic [DEPTH:0]    base_q, base_d;
  logic [FRAMES:0]   fsp_q, fsp_d;
  logic [DEPTH:0]    r_q, r_d;
  logic [DEPTH:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]  tos_q, tos_d;
  logic [1:0]        status_q, status_d;
  logic              ferr_q, ferr_d;

  // Operand storage and saved caller frame bases; neither is cleared on reset.
  logic [WIDTH-1:0]  mem_q [0:ENTRIES-1];
  logic [DEPTH:0]    fbs_q [0:NFRAMES-1];

  logic              mem_we;
  logic [DEPTH-1:0]  mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              fbs_we;
  logic [FRAMES-1:0] fbs_waddr;
  logic [DEPTH:0]    fbs_wdata;

  // Derived indices shared by the next-state logic.
  logic [DEPTH:0]    idx_m1, idx_m2, base_m1, used, copy_dst, copy_src, r_m1, commit_idx;
  logic [FRAMES:0]   fsp_m1;
  logic [DEPTH:0]    popped;
  logic              unused_bits;

  assign idx_m1     = idx_q - ONE_D;
  assign idx_m2     = idx_q - TWO_D;
  assign base_m1    = base_q - ONE_D;
  assign used       = idx_q - base_q;
  assign copy_dst   = base_q + cnt_q;
  assign copy_src   = idx_q - r_q + cnt_q;
  assign r_m1       = r_q - ONE_D;
  assign commit_idx = base_q + r_q;
  assign fsp_m1     = fsp_q - ONE_F;
  assign popped     = fbs_q[fsp_m1[FRAMES-1:0]];

  // Top bits of the memory/frame addresses are never needed for indexing.
  assign unused_bits = ^{idx_m1[DEPTH], idx_m2[DEPTH], base_m1[DEPTH],
                         copy_dst[DEPTH], copy_src[DEPTH], fsp_m1[FRAMES]};

  // Next-state logic: frame ops take priority over stack ops; COPY ignores inputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    fsp_d     = fsp_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    tos_d     = tos_q;
    status_d  = status_q;
    ferr_d    = ferr_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    fbs_we    = 1'b0;
    fbs_waddr = '0;
    fbs_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (frame_op_i == FOP_ENTER) begin
          if (fsp_q == FCAP || frame_args_i > used) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d    = 1'b0;
            fbs_we    = 1'b1;
            fbs_waddr = fsp_q[FRAMES-1:0];
            fbs_wdata = base_q;
            base_d    = idx_q - frame_args_i;
            fsp_d     = fsp_q + ONE_F;
            status_d  = (frame_args_i == '0) ? ST_EMPTY : ST_NONE;
          end
        end else if (frame_op_i == FOP_LEAVE) begin
          if (fsp_q == '0 || frame_results_i > used) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d = 1'b0;
            if (frame_results_i == '0) begin
              // Nothing to return: drop the frame in a single cycle.
              idx_d    = base_q;
              base_d   = popped;
              fsp_d    = fsp_m1;
              status_d = (base_q == popped) ? ST_EMPTY : ST_NONE;
              if (base_q != '0) begin
                tos_d = mem_q[base_m1[DEPTH-1:0]];
              end
            end else begin
              r_d     = frame_results_i;
              cnt_d   = '0;
              state_d = S_COPY;
            end
          end
        end else begin
          case (op_i)
            OP_PUSH: begin
              if (idx_q == CAP) begin
                status_d = ST_OVERFLOW;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = idx_q[DEPTH-1:0];
                mem_wdata = data_i;
                idx_d     = idx_q + ONE_D;
                tos_d     = data_i;
                status_d  = ST_NONE;
              end
            end
            OP_POP: begin
              if (idx_q == base_q) begin
                status_d = ST_UNDERFLOW;
              end else begin
                idx_d    = idx_m1;
                status_d = (idx_m1 == base_q) ? ST_EMPTY : ST_NONE;
                if (idx_m1 != '0) begin
                  tos_d = mem_q[idx_m2[DEPTH-1:0]];
                end
              end
            end
            OP_REPLACE: begin
              if (idx_q == base_q) begin
                status_d = ST_UNDERFLOW;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = idx_m1[DEPTH-1:0];
                mem_wdata = data_i;
                tos_d     = data_i;
                status_d  = ST_NONE;
              end
            end
            default: begin
              status_d = (idx_q == base_q) ? ST_EMPTY : ST_NONE;
            end
          endcase
        end
      end

      S_COPY: begin
        // Ascending copy is safe because the destination never lies above the source.
        mem_we    = 1'b1;
        mem_waddr = copy_dst[DEPTH-1:0];
        mem_wdata = mem_q[copy_src[DEPTH-1:0]];
        if (cnt_q == r_m1) begin
          // Last result moved: commit the caller's frame. The new top is the
          // last source entry, which the copy has not overwritten.
          idx_d    = commit_idx;
          base_d   = popped;
          fsp_d    = fsp_m1;
          tos_d    = mem_q[idx_m1[DEPTH-1:0]];
          status_d = (commit_idx == popped) ? ST_EMPTY : ST_NONE;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_D;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      fsp_q    <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      tos_q    <= '0;
      status_q <= ST_EMPTY;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      fsp_q    <= fsp_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      tos_q    <= tos_d;
      status_q <= status_d;
      ferr_q   <= ferr_d;
    end
  end

  // Operand memory write port.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Frame-base stack write port.
  always_ff @(posedge clk_i) begin
    if (fbs_we) begin
      fbs_q[fbs_waddr] <= fbs_wdata;
    end
  end

  assign tos_o         = tos_q;
  assign status_o      = status_q;
  assign frame_err_o   = ferr_q;
  assign busy_o        = (state_q == S_COPY);
  assign frame_depth_o = fsp_q;

endmodule

// File: tb/tb_frame_stack.sv
// tb_frame_stack: directed and random stimulus against a queue-based model.
module tb_frame_stack;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int FRAMES = 2;
  localparam int CAPN   = 16;
  localparam int MAXF   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        op;
  logic [WIDTH-1:0]  data;
  logic [1:0]        frame_op;
  logic [DEPTH:0]    frame_args;
  logic [DEPTH:0]    frame_results;
  logic [WIDTH-1:0]  tos;
  logic [1:0]        status;
  logic              frame_err;
  logic              busy;
  logic [FRAMES:0]   frame_depth;

  always #5 clk = ~clk;

  frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .op_i            (op),
    .data_i          (data),
    .frame_op_i      (frame_op),
    .frame_args_i    (frame_args),
    .frame_results_i (frame_results),
    .tos_o           (tos),
    .status_o        (status),
    .frame_err_o     (frame_err),
    .busy_o          (busy),
    .frame_depth_o   (frame_depth)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: whole stack as a queue, saved bases as a queue.
  int q[$];
  int fb[$];
  int tmp[$];
  int m_base, m_tos, m_status, m_ferr, m_busy, m_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int empty_status();
    return (q.size() == m_base) ? 1 : 0;
  endfunction

  task automatic model_reset();
    q.delete();
    fb.delete();
    m_base = 0; m_tos = 0; m_status = 1; m_ferr = 0; m_busy = 0; m_r = 0;
  endtask

  task automatic model_step(input int o, input int d, input int fop, input int a, input int r);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        tmp.delete();
        for (int i = q.size() - m_r; i < q.size(); i++) tmp.push_back(q[i]);
        while (q.size() > m_base) void'(q.pop_back());
        foreach (tmp[i]) q.push_back(tmp[i]);
        m_base   = fb.pop_back();
        m_tos    = q[q.size() - 1];
        m_status = empty_status();
      end
    end else if (fop == 1) begin
      if (fb.size() == MAXF || a > q.size() - m_base) m_ferr = 1;
      else begin
        m_ferr = 0;
        fb.push_back(m_base);
        m_base   = q.size() - a;
        m_status = empty_status();
      end
    end else if (fop == 2) begin
      if (fb.size() == 0 || r > q.size() - m_base) m_ferr = 1;
      else begin
        m_ferr = 0;
        if (r == 0) begin
          while (q.size() > m_base) void'(q.pop_back());
          m_base = fb.pop_back();
          if (q.size() > 0) m_tos = q[q.size() - 1];
          m_status = empty_status();
        end else begin
          m_busy = r;
          m_r    = r;
        end
      end
    end else begin
      case (o)
        1: if (q.size() == CAPN) m_status = 2;
           else begin q.push_back(d); m_tos = d; m_status = 0; end
        2: if (q.size() == m_base) m_status = 3;
           else begin
             void'(q.pop_back());
             if (q.size() > 0) m_tos = q[q.size() - 1];
             m_status = empty_status();
           end
        3: if (q.size() == m_base) m_status = 3;
           else begin q[q.size() - 1] = d; m_tos = d; m_status = 0; end
        default: m_status = empty_status();
      endcase
    end
  endtask

  task automatic check_out(input string ctx);
    check({ctx, ".tos"},    32'(tos),         32'(m_tos));
    check({ctx, ".status"}, 32'(status),      32'(m_status));
    check({ctx, ".ferr"},   32'(frame_err),   32'(m_ferr));
    check({ctx, ".busy"},   32'(busy),        32'(m_busy > 0 ? 1 : 0));
    check({ctx, ".depth"},  32'(frame_depth), 32'(fb.size()));
  endtask

  // One clock transaction: drive, clock, update model, sample 1 time unit later.
  task automatic step(input int o, input int d, input int fop, input int a, input int r);
    op            = 2'(o);
    data          = 8'(d);
    frame_op      = 2'(fop);
    frame_args    = 5'(a);
    frame_results = 5'(r);
    @(posedge clk);
    model_step(o, d, fop, a, r);
    #1;
    check_out("cyc");
    $display("op=%0d d=%02h fop=%0d a=%0d r=%0d -> tos=%02h st=%0d ferr=%0d busy=%0d dep=%0d",
             o, d, fop, a, r, tos, status, frame_err, busy, frame_depth);
  endtask

  // Called 1 time unit after a rising edge; reset pulse ends before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    op = '0; data = '0; frame_op = '0; frame_args = '0; frame_results = '0;
    #2;
    model_reset();
    check_out("rst");
    $display("reset -> tos=%02h st=%0d ferr=%0d busy=%0d dep=%0d",
             tos, status, frame_err, busy, frame_depth);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic push3();
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    op = '0; data = '0; frame_op = '0; frame_args = '0; frame_results = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_status", 32'(status), 32'd1);

    // Underflow on empty, then basic pushes.
    step(2, 0, 0, 0, 0);
    check("pop_empty", 32'(status), 32'd3);
    push3();
    check("push3_tos", 32'(tos), 32'd3);
    check("push3_status", 32'(status), 32'd0);

    // Fill to capacity then overflow.
    do_reset();
    for (int i = 0; i < CAPN; i++) step(1, 16'h20 + i, 0, 0, 0);
    step(1, 9, 0, 0, 0);
    check("ovf_status", 32'(status), 32'd2);
    check("ovf_tos", 32'(tos), 32'h2f);

    // Frame base is the underflow limit.
    do_reset();
    push3();
    step(0, 0, 1, 1, 0);
    check("enter_status", 32'(status), 32'd0);
    check("enter_depth", 32'(frame_depth), 32'd1);
    step(2, 0, 0, 0, 0);
    check("frame_pop_empty", 32'(status), 32'd1);
    step(2, 0, 0, 0, 0);
    check("frame_pop_udf", 32'(status), 32'd3);

    // LEAVE with two results; inputs during COPY must be ignored.
    do_reset();
    push3();
    step(0, 0, 1, 1, 0);
    step(1, 7, 0, 0, 0);
    step(1, 8, 0, 0, 0);
    step(0, 0, 2, 0, 2);
    check("leave_busy1", 32'(busy), 32'd1);
    step(1, 8'h55, 1, 0, 0);
    check("leave_busy2", 32'(busy), 32'd1);
    step(3, 8'h66, 0, 0, 0);
    check("leave_done_busy", 32'(busy), 32'd0);
    check("leave_tos", 32'(tos), 32'd8);
    check("leave_depth", 32'(frame_depth), 32'd0);
    step(2, 0, 0, 0, 0);
    check("after_leave_pop1", 32'(tos), 32'd7);
    step(2, 0, 0, 0, 0);
    check("after_leave_pop2", 32'(tos), 32'd2);
    step(2, 0, 0, 0, 0);
    check("after_leave_pop3", 32'(tos), 32'd1);

    // Rejected frame ops.
    do_reset();
    step(0, 0, 2, 0, 0);
    check("leave_nodepth", 32'(frame_err), 32'd1);
    push3();
    check("ferr_sticky", 32'(frame_err), 32'd1);
    step(0, 0, 1, 3, 0);
    check("ferr_cleared", 32'(frame_err), 32'd0);
    step(0, 0, 1, 5, 0);
    check("enter_too_many", 32'(frame_err), 32'd1);
    step(0, 0, 2, 0, 4);
    check("leave_too_many", 32'(frame_err), 32'd1);
    step(0, 0, 2, 0, 0);
    check("leave_r0_depth", 32'(frame_depth), 32'd0);

    // Frame nesting limit.
    do_reset();
    for (int i = 0; i < MAXF; i++) step(0, 0, 1, 0, 0);
    check("enter4_ok", 32'(frame_err), 32'd0);
    check("enter4_depth", 32'(frame_depth), 32'd4);
    step(0, 0, 1, 0, 0);
    check("enter5_err", 32'(frame_err), 32'd1);

    // Reset in the middle of a copy.
    do_reset();
    push3();
    step(0, 0, 1, 2, 0);
    step(1, 4, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(0, 0, 2, 0, 3);
    step(0, 0, 0, 0, 0);
    do_reset();
    check("midcopy_status", 32'(status), 32'd1);
    check("midcopy_busy", 32'(busy), 32'd0);
    step(1, 8'hab, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int sel, fop;
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #1;
        do_reset();
      end
      sel = int'($urandom_range(0, 9));
      fop = (sel < 7) ? 0 : (sel == 7) ? 1 : (sel == 8) ? 2 : 3;
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), fop,
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
